spi_responder: RTL and testbench
================================

# spi_responder

SPI responder (slave) that sits on the far end of the team's byte-wide SPI master link and is used to model and bench the SD/peripheral side. It runs from a fast system clock, samples the external SPI_CLK, SPI_MOSI and SPI_CS_n through synchronizers, and delivers each received byte with a one-cycle strobe. In the same transfer it shifts out a transmit byte that the local logic supplies through a one-deep holding register. The bus uses SPI mode 3: clock idles high, MISO changes on the falling edge, both sides sample on the rising edge, MSB first.

## Interface
- IDLE_BYTE, 8'hFF: byte shifted out when no transmit byte is pending (SD idle pattern).
- CLK  input  1  system clock; all logic is on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- SPI_CLK  input  1  serial clock from the master; idles high; asynchronous to CLK.
- SPI_CS_n  input  1  chip select, active low; asynchronous.
- SPI_MOSI  input  1  serial data from the master.
- SPI_MISO  output  1  serial data to the master; registered.
- RxData  output  8  last complete received byte.
- RxValid  output  1  one-CLK pulse when RxData updates.
- TxData  input  8  byte to transmit.
- TxLoad  input  1  write strobe for TxData; accepted only when TxReady=1.
- TxReady  output  1  holding register empty.
- TxUnderrun  output  1  one-CLK pulse when a byte boundary finds the holding register empty and IDLE_BYTE is used instead.
- Busy  output  1  synchronized CS active (state ACTIVE).

## Operation
- Reset values: SPI_MISO=1, RxData=0, RxValid=0, TxReady=1, TxUnderrun=0, Busy=0, bit counter=0, state IDLE, current transmit byte=IDLE_BYTE.
- Synchronizers: SPI_CLK, SPI_CS_n and SPI_MOSI each pass through 2 flip-flops. Rising and falling edges of SPI_CLK are detected from the synchronized value and its one-cycle delay.
- FSM states:
  - IDLE: entered when synced CS goes high. SPI_MISO=1 and SPI_CLK edges are ignored.
  - ACTIVE: entered when synced CS goes low.
- IDLE->ACTIVE (synced CS falls):
  - bitcnt<=0.
  - Current byte loads from the holding register, or IDLE_BYTE with a TxUnderrun pulse if the register is empty.
  - SPI_MISO<=current[7].
- In ACTIVE, rising edge:
  - Shift synced MOSI into the receive register LSB.
  - bitcnt<=bitcnt+1, 3-bit, wraps.
  - When bitcnt was 7 (byte boundary):
    - RxData<=the 8 assembled bits and RxValid pulses for 1 cycle.
    - Current byte reloads from the holding register, or IDLE_BYTE with TxUnderrun.
- In ACTIVE, falling edge: SPI_MISO<=current[7-bitcnt]. After a boundary this drives the MSB of the newly loaded byte.
- Holding register:
  - TxLoad with TxReady=1 captures TxData and drops TxReady on the next cycle.
  - TxLoad with TxReady=0 is ignored.
  - A boundary or CS-fall reload empties the register, and TxReady=1 the next cycle.
- Simultaneous TxLoad and reload in the same cycle:
  - The reload sees the old register contents. If the register was empty, it takes IDLE_BYTE with TxUnderrun.
  - TxData is captured into the register for the next byte.
- CS high mid-byte:
  - Move to IDLE.
  - Discard the partial receive byte; no RxValid.
  - The current transmit byte counts as consumed.
- Reset mid-byte: all state returns to reset values immediately, asynchronously; the holding contents are lost.

## Timing
- SPI_CLK high and low phases are each ≥3 CLK periods, and SPI_CS_n setup/hold around SPI_CLK edges is ≥3 CLK periods. Faster input is out of scope.
- Pin-to-internal latency is 3 CLK for a rising edge of SPI_CLK: 2 synchronizer stages plus the edge register.
- RxValid is asserted 3–4 CLK after the pin rising edge of bit 7.
- SPI_MISO settles ≤4 CLK after the pin falling edge of SPI_CLK, or after SPI_CS_n falls. This is well before the next rising edge given the phase minimum above.
- MOSI is captured with the same synchronizer delay as SPI_CLK, so the sampled bit is the one present at the pin rising edge.

## Structure
- Shared package spi_pkg holds:
  - IDLE_BYTE default;
  - SYNC_STAGES=2;
  - the state enum {IDLE, ACTIVE}.
- Sub-module spi_sync_edge: a 2-FF synchronizer plus rise/fall pulse outputs.
  - One instance for SPI_CLK.
  - Plain synchronizer instances for SPI_CS_n and SPI_MOSI.
- Top level holds the FSM, bitcnt, receive shifter, current/holding transmit registers and the MISO register.

## Test plan
- Reset, then idle 20 cycles -> SPI_MISO=1, TxReady=1, RxData=0x00, no strobes.
- TxLoad 0xA5; CS low; master sends 0x3C at SPI_CLK=CLK/8 -> RxData=0x3C with a single RxValid pulse; master samples MISO bits 1,0,1,0,0,1,0,1.
- Load 0x12, then load 0x34 during byte 1; run three bytes -> MISO bytes 0x12, 0x34, 0xFF; one TxUnderrun at boundary 2.
- CS high after 5 rising edges, then a new 8-bit transfer of 0x81 -> no RxValid for the aborted byte; RxData=0x81 afterwards.
- TxLoad 0x55 while TxReady=0 -> ignored; the held value is transmitted unchanged.
- Reset asserted mid-byte (bit 4) -> outputs return to reset values immediately; next transfer after release receives 0xC3 correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and state type for the SPI responder.
// Holds the idle fill byte, synchronizer depth and FSM state enum.
package spi_pkg;

  localparam logic [7:0] IDLE_BYTE   = 8'hFF;
  localparam int         SYNC_STAGES = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/spi_responder_if.sv
// spi_responder_if: SPI pins plus the local byte-side handshake.
// slave = responder side, master = SPI master / local logic side.
interface spi_responder_if;

  logic       SPI_CLK;
  logic       SPI_CS_n;
  logic       SPI_MOSI;
  logic       SPI_MISO;
  logic [7:0] RxData;
  logic       RxValid;
  logic [7:0] TxData;
  logic       TxLoad;
  logic       TxReady;
  logic       TxUnderrun;
  logic       Busy;

  modport slave (
    input  SPI_CLK, SPI_CS_n, SPI_MOSI,
    input  TxData, TxLoad,
    output SPI_MISO, RxData, RxValid,
    output TxReady, TxUnderrun, Busy
  );

  modport master (
    output SPI_CLK, SPI_CS_n, SPI_MOSI,
    output TxData, TxLoad,
    input  SPI_MISO, RxData, RxValid,
    input  TxReady, TxUnderrun, Busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: SYNC_STAGES-flop synchronizer with rise/fall pulses.
// Ports: i_clk, i_rst, i_d (async in), o_q (synced), o_rise, o_fall.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/spi_responder.sv
// spi_responder: SPI mode-3 slave, byte receive strobe, 1-deep tx hold.
// Ports: CLK, Reset (async high), bus (spi_responder_if.slave).
module spi_responder
  import spi_pkg::*;
(
  input  logic           CLK,
  input  logic           Reset,
  spi_responder_if.slave bus
);

  logic w_sclk, w_sclk_rise, w_sclk_fall;
  logic w_cs_n, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sclk (
    .i_clk(CLK), .i_rst(Reset), .i_d(bus.SPI_CLK),
    .o_q(w_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .i_clk(CLK), .i_rst(Reset), .i_d(bus.SPI_CS_n),
    .o_q(w_cs_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .i_clk(CLK), .i_rst(Reset), .i_d(bus.SPI_MOSI),
    .o_q(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  logic w_unused;
  assign w_unused = ^{w_sclk, w_cs_rise, w_cs_fall,
                      w_mosi_rise, w_mosi_fall};

  state_t     r_state, w_state_nxt;
  logic [2:0] r_bitcnt;
  logic [6:0] r_shift;
  logic [7:0] r_cur, r_hold, r_rx_data;
  logic       r_hold_vld, r_miso, r_rx_valid, r_underrun;

  logic       w_start, w_rise, w_fall;
  logic       w_boundary, w_reload, w_accept;
  logic [7:0] w_next_cur;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // SPI_CLK edges only count while CS stays low
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_cs_n) begin
          w_state_nxt = ACTIVE;
          w_start     = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_cs_n) begin
          w_state_nxt = IDLE;
        end else begin
          w_rise = w_sclk_rise;
          w_fall = w_sclk_fall;
        end
      end
    endcase
  end

  assign w_boundary = w_rise & (r_bitcnt == 3'd7);
  assign w_reload   = w_start | w_boundary;
  assign w_accept   = bus.TxLoad & ~r_hold_vld;
  assign w_next_cur = r_hold_vld ? r_hold : IDLE_BYTE;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_miso     <= 1'b1;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_bitcnt   <= 3'd0;
      r_shift    <= 7'd0;
      r_cur      <= IDLE_BYTE;
      r_hold     <= 8'h00;
      r_hold_vld <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      if (w_reload) begin
        r_cur      <= w_next_cur;
        r_underrun <= ~r_hold_vld;
      end
      // a load in the reload cycle refills for the next byte
      if (w_accept) begin
        r_hold     <= bus.TxData;
        r_hold_vld <= 1'b1;
      end else if (w_reload) begin
        r_hold_vld <= 1'b0;
      end
      if (w_start) begin
        r_bitcnt <= 3'd0;
        r_miso   <= w_next_cur[7];
      end
      if (w_rise) begin
        r_shift  <= {r_shift[5:0], w_mosi};
        r_bitcnt <= r_bitcnt + 3'd1;
        if (w_boundary) begin
          r_rx_data  <= {r_shift, w_mosi};
          r_rx_valid <= 1'b1;
        end
      end
      if (w_fall) r_miso <= r_cur[3'd7 - r_bitcnt];
      if (w_state_nxt == IDLE) r_miso <= 1'b1;
    end
  end

  assign bus.SPI_MISO   = r_miso;
  assign bus.RxData     = r_rx_data;
  assign bus.RxValid    = r_rx_valid;
  assign bus.TxReady    = ~r_hold_vld;
  assign bus.TxUnderrun = r_underrun;
  assign bus.Busy       = (r_state == ACTIVE);

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: scoreboard bench for spi_responder.
// Master model drives mode-3 bytes at CLK/8; rx/miso bytes queued.
module tb_spi_responder;

  logic CLK = 1'b0;
  logic Reset;

  spi_responder_if bus ();

  spi_responder dut (
    .CLK(CLK),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  int rx_cnt = 0;
  int ur_cnt = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.TxUnderrun) ur_cnt++;
    if (bus.RxValid) begin
      rx_cnt++;
      if (exp_rx.size() == 0) chk("rx_unexp", exp_rx.size(), 1);
      else chk("rx_data", bus.RxData, exp_rx.pop_front());
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic load(logic [7:0] d);
    bus.TxData = d;
    bus.TxLoad = 1'b1;
    cyc(1);
    bus.TxLoad = 1'b0;
  endtask

  task automatic cs_low;
    bus.SPI_CS_n = 1'b0;
    cyc(4);
  endtask

  task automatic cs_high;
    cyc(4);
    bus.SPI_CS_n = 1'b1;
    cyc(6);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nb,
                      output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      bus.SPI_CLK  = 1'b0;
      bus.SPI_MOSI = tx[i];
      cyc(4);
      mi = {mi[6:0], bus.SPI_MISO};
      bus.SPI_CLK = 1'b1;
      cyc(4);
    end
  endtask

  task automatic send_byte(logic [7:0] tx, logic [7:0] mi_exp);
    logic [7:0] mi;
    exp_rx.push_back(tx);
    exp_miso.push_back(mi_exp);
    xfer(tx, 8, mi);
    chk("miso_byte", mi, exp_miso.pop_front());
  endtask

  initial begin
    int u0, r0;
    logic [7:0] mi;

    Reset        = 1'b1;
    bus.SPI_CLK  = 1'b1;
    bus.SPI_CS_n = 1'b1;
    bus.SPI_MOSI = 1'b0;
    bus.TxData   = 8'h00;
    bus.TxLoad   = 1'b0;
    cyc(3);
    Reset = 1'b0;
    cyc(20);
    chk("rst_miso", bus.SPI_MISO, 1);
    chk("rst_txready", bus.TxReady, 1);
    chk("rst_rxdata", bus.RxData, 8'h00);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_rx_cnt", rx_cnt, 0);
    chk("rst_ur_cnt", ur_cnt, 0);

    // basic byte with preloaded tx
    load(8'hA5);
    chk("load_txready", bus.TxReady, 0);
    cs_low;
    chk("cs_busy", bus.Busy, 1);
    chk("cs_txready", bus.TxReady, 1);
    send_byte(8'h3C, 8'hA5);
    cs_high;
    chk("b1_rx_cnt", rx_cnt, 1);
    chk("b1_ur_cnt", ur_cnt, 1);
    chk("b1_rxdata", bus.RxData, 8'h3C);
    chk("b1_busy", bus.Busy, 0);
    chk("b1_miso_idle", bus.SPI_MISO, 1);

    // back-to-back bytes with a refill during byte 1
    u0 = ur_cnt;
    r0 = rx_cnt;
    load(8'h12);
    cs_low;
    load(8'h34);
    send_byte(8'hA1, 8'h12);
    chk("m1_ur", ur_cnt - u0, 0);
    send_byte(8'hB2, 8'h34);
    chk("m2_ur", ur_cnt - u0, 1);
    send_byte(8'h7E, 8'hFF);
    cs_high;
    chk("m3_ur", ur_cnt - u0, 2);
    chk("m_rx_cnt", rx_cnt - r0, 3);

    // aborted byte then full byte
    r0 = rx_cnt;
    cs_low;
    xfer(8'hF0, 5, mi);
    cs_high;
    chk("abort_rx_cnt", rx_cnt - r0, 0);
    cs_low;
    send_byte(8'h81, 8'hFF);
    cs_high;
    chk("after_abort_rxdata", bus.RxData, 8'h81);
    chk("after_abort_rx_cnt", rx_cnt - r0, 1);

    // load while full is ignored
    load(8'h66);
    load(8'h55);
    chk("full_txready", bus.TxReady, 0);
    cs_low;
    send_byte(8'h5A, 8'h66);
    cs_high;

    // reset in the middle of a byte
    load(8'h77);
    cs_low;
    xfer(8'h99, 4, mi);
    chk("part_miso", mi, 8'h07);
    bus.SPI_CLK = 1'b0;
    cyc(2);
    Reset = 1'b1;
    #1;
    chk("mid_rst_miso", bus.SPI_MISO, 1);
    chk("mid_rst_rxdata", bus.RxData, 8'h00);
    chk("mid_rst_txready", bus.TxReady, 1);
    chk("mid_rst_busy", bus.Busy, 0);
    bus.SPI_CLK  = 1'b1;
    bus.SPI_CS_n = 1'b1;
    cyc(3);
    Reset = 1'b0;
    cyc(4);
    cs_low;
    send_byte(8'hC3, 8'hFF);
    cs_high;
    chk("post_rst_rxdata", bus.RxData, 8'hC3);
    chk("rxq_empty", exp_rx.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
